// File: rtl/bcd_display_formatter.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (double-dabble, one bit per clock)
// with saturation above 9999 and optional leading-zero digit blanking for a 7-segment controller.
module bcd_display_formatter #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_display,
  output logic        overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [3:0]  RST_MASK  = BLANK_LEADING ? 4'b0001 : 4'b1111;
  localparam logic [15:0] MAX_SHOWN = 16'd9999;

  // Add-3 correction applied to every BCD digit that would overflow when doubled.
  function automatic logic [15:0] add3_digits(input logic [15:0] acc);
    logic [15:0] r;
    r = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      if (acc[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = acc[4*k +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] digit_mask(input logic [15:0] acc, input logic ovf);
    logic [3:0] m;
    m = 4'b1111;
    if (BLANK_LEADING && !ovf) begin
      m[3] = |acc[15:12];
      m[2] = |acc[15:8];
      m[1] = |acc[15:4];
      m[0] = 1'b1;
    end else begin
      m = 4'b1111;
    end
    return m;
  endfunction

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  disp_q, disp_d;
  logic        ovf_q, ovf_d;
  logic [15:0] acc_adj_s;

  assign acc_adj_s = add3_digits(acc_q);

  // Next-state and datapath: capture, 14 shift-add-3 steps, then publish the result.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Bits [15:14] only matter for the saturation compare.
          bin_d      = value[13:0];
          acc_d      = 16'h0000;
          ovf_pend_d = (value > MAX_SHOWN);
          cnt_d      = 4'd13;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d = {acc_adj_s[14:0], bin_q[13]};
        bin_d = {bin_q[12:0], 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_LOAD: begin
        bcd_d   = ovf_pend_q ? 16'h9999 : acc_q;
        ovf_d   = ovf_pend_q;
        disp_d  = digit_mask(acc_q, ovf_pend_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bin_q      <= 14'd0;
      acc_q      <= 16'h0000;
      cnt_q      <= 4'd0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= 16'h0000;
      disp_q     <= RST_MASK;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bcd_out       = bcd_q;
  assign digit_display = disp_q;
  assign overflow      = ovf_q;

endmodule
